// File: rtl/instr_fetch_if.sv
// Fetch-unit signal bundle: program control, decoder flags,
// jump-target LUT writes, instruction memory and status.
interface instr_fetch_if #(
    parameter int PC_W = 10
);
    logic            Start;
    logic            Stall;
    logic            Halt;
    logic            Jump;
    logic            Branch;
    logic            Jen;
    logic [4:0]      Jptr;
    logic            Lut_we;
    logic [4:0]      Lut_idx;
    logic [PC_W-1:0] Lut_data;
    logic [8:0]      Imem_data;
    logic [PC_W-1:0] Imem_addr;
    logic [8:0]      Mach_code;
    logic            Valid;
    logic            Done;
    logic [15:0]     Inst_count;

    modport master (
        output Start,
        output Stall,
        output Halt,
        output Jump,
        output Branch,
        output Jen,
        output Jptr,
        output Lut_we,
        output Lut_idx,
        output Lut_data,
        output Imem_data,
        input  Imem_addr,
        input  Mach_code,
        input  Valid,
        input  Done,
        input  Inst_count
    );

    modport slave (
        input  Start,
        input  Stall,
        input  Halt,
        input  Jump,
        input  Branch,
        input  Jen,
        input  Jptr,
        input  Lut_we,
        input  Lut_idx,
        input  Lut_data,
        input  Imem_data,
        output Imem_addr,
        output Mach_code,
        output Valid,
        output Done,
        output Inst_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, LUT-based jumps/branches,
// halt handling and retired-instruction counter.
module instr_fetch #(
    parameter int PC_W  = 10,
    parameter int LUT_N = 32
) (
    input  logic          Clk,
    input  logic          Reset_n,
    instr_fetch_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_MAX = '1;
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [15:0]     CNT_MAX = 16'hFFFF;

    state_t          state;
    state_t          state_n;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_n;
    logic [15:0]     cnt;
    logic [15:0]     cnt_n;
    logic [15:0]     cnt_inc;
    logic [PC_W-1:0] lut [LUT_N];
    logic [PC_W-1:0] target;
    logic            take;
    logic            pc_end;
    logic            in_run;

    assign target  = lut[bus.Jptr];
    assign take    = bus.Jump | (bus.Branch & bus.Jen);
    assign pc_end  = (pc == PC_MAX);
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 16'd1;
    assign in_run  = (state == RUN);

    assign bus.Imem_addr  = pc;
    assign bus.Valid      = in_run;
    assign bus.Mach_code  = in_run ? bus.Imem_data : 9'h000;
    assign bus.Done       = (state == HALTED);
    assign bus.Inst_count = cnt;

    // Jump-target table: writable only while idle, survives reset
    always_ff @(posedge Clk) begin
        if (bus.Lut_we && (state == IDLE)) begin
            lut[bus.Lut_idx] <= bus.Lut_data;
        end
    end

    // State, PC and counter registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
        end
    end

    // Next state / PC / count; halt beats jump beats sequential
    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        unique case (state)
            IDLE, HALTED: begin
                if (bus.Start) begin
                    state_n = RUN;
                    pc_n    = '0;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                if (!bus.Stall) begin
                    cnt_n = cnt_inc;
                    if (bus.Halt) begin
                        state_n = HALTED;
                    end else if (take) begin
                        pc_n = target;
                    end else if (pc_end) begin
                        state_n = HALTED;
                    end else begin
                        pc_n = pc + PC_ONE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = '0;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_instr_fetch;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(10)) bus ();

    logic [8:0] rom [1024];

    assign bus.Imem_data = rom[bus.Imem_addr];

    instr_fetch #(
        .PC_W  (10),
        .LUT_N (32)
    ) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_mode;
    int m_pc;
    int m_cnt;
    int m_lut [32];

    function automatic logic [8:0] exp_mach();
        if (m_mode == M_RUN) return rom[m_pc];
        return 9'h000;
    endfunction

    task automatic clear_inputs();
        bus.Start    = 1'b0;
        bus.Stall    = 1'b0;
        bus.Halt     = 1'b0;
        bus.Jump     = 1'b0;
        bus.Branch   = 1'b0;
        bus.Jen      = 1'b0;
        bus.Jptr     = 5'd0;
        bus.Lut_we   = 1'b0;
        bus.Lut_idx  = 5'd0;
        bus.Lut_data = 10'd0;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        if (m_mode == M_IDLE) begin
            if (bus.Lut_we) m_lut[bus.Lut_idx] = int'(bus.Lut_data);
            if (bus.Start) begin
                m_mode = M_RUN;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end else if (m_mode == M_HALT) begin
            if (bus.Start) begin
                m_mode = M_RUN;
                m_pc   = 0;
                m_cnt  = 0;
            end
        end else if (!bus.Stall) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (bus.Halt) m_mode = M_HALT;
            else if (bus.Jump || (bus.Branch && bus.Jen))
                m_pc = m_lut[bus.Jptr];
            else if (m_pc == 1023) m_mode = M_HALT;
            else m_pc = m_pc + 1;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.Valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %0b exp 0", bus.Valid);
        end
        checks++;
        if (bus.Done !== 1'b0) begin
            errors++;
            $display("FAIL rst_done got %0b exp 0", bus.Done);
        end
        checks++;
        if (bus.Imem_addr !== 10'd0) begin
            errors++;
            $display("FAIL rst_pc got %0d exp 0", bus.Imem_addr);
        end
        checks++;
        if (bus.Mach_code !== 9'h000) begin
            errors++;
            $display("FAIL rst_mach got %h exp 000", bus.Mach_code);
        end
        checks++;
        if (bus.Inst_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_cnt got %0d exp 0", bus.Inst_count);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        checks++;
        if (bus.Valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got valid %0b exp 0", bus.Valid);
        end
    endtask

    task automatic test_sequential();
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.Imem_addr !== 10'(i)) begin
                errors++;
                $display("FAIL seq_pc got %0d exp %0d", bus.Imem_addr, i);
            end
            checks++;
            if (bus.Mach_code !== rom[i] || bus.Valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_mach got %h/%0b exp %h/1",
                         bus.Mach_code, bus.Valid, rom[i]);
            end
            cycle();
        end
        checks++;
        if (bus.Inst_count !== 16'd5) begin
            errors++;
            $display("FAIL seq_cnt got %0d exp 5", bus.Inst_count);
        end
    endtask

    task automatic test_jump_branch();
        do_reset();
        bus.Lut_we   = 1'b1;
        bus.Lut_idx  = 5'd3;
        bus.Lut_data = 10'd40;
        bus.Start    = 1'b1;
        cycle();
        clear_inputs();
        checks++;
        if (bus.Valid !== 1'b1 || bus.Inst_count !== 16'd0) begin
            errors++;
            $display("FAIL jb_start got valid %0b cnt %0d exp 1/0",
                     bus.Valid, bus.Inst_count);
        end
        repeat (7) cycle();
        checks++;
        if (bus.Imem_addr !== 10'd7) begin
            errors++;
            $display("FAIL jb_pc7 got %0d exp 7", bus.Imem_addr);
        end
        bus.Jump = 1'b1;
        bus.Jptr = 5'd3;
        cycle();
        bus.Jump = 1'b0;
        checks++;
        if (bus.Imem_addr !== 10'd40) begin
            errors++;
            $display("FAIL jb_jump got %0d exp 40", bus.Imem_addr);
        end
        bus.Branch = 1'b1;
        bus.Jen    = 1'b0;
        cycle();
        checks++;
        if (bus.Imem_addr !== 10'd41) begin
            errors++;
            $display("FAIL jb_br_nt got %0d exp 41", bus.Imem_addr);
        end
        bus.Jen = 1'b1;
        cycle();
        checks++;
        if (bus.Imem_addr !== 10'd40) begin
            errors++;
            $display("FAIL jb_br_t got %0d exp 40", bus.Imem_addr);
        end
        clear_inputs();
    endtask

    task automatic test_stall_priority();
        do_reset();
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        repeat (5) cycle();
        bus.Stall = 1'b1;
        bus.Halt  = 1'b1;
        bus.Jump  = 1'b1;
        bus.Jptr  = 5'd3;
        cycle();
        checks++;
        if (bus.Imem_addr !== 10'd5 || bus.Valid !== 1'b1 ||
            bus.Done !== 1'b0 || bus.Inst_count !== 16'd5) begin
            errors++;
            $display("FAIL stall got pc %0d v %0b d %0b c %0d exp 5/1/0/5",
                     bus.Imem_addr, bus.Valid, bus.Done,
                     bus.Inst_count);
        end
        bus.Stall = 1'b0;
        cycle();
        clear_inputs();
        checks++;
        if (bus.Imem_addr !== 10'd5 || bus.Done !== 1'b1 ||
            bus.Valid !== 1'b0 || bus.Mach_code !== 9'h000) begin
            errors++;
            $display("FAIL halt_prio got pc %0d d %0b v %0b m %h exp 5/1/0/000",
                     bus.Imem_addr, bus.Done, bus.Valid, bus.Mach_code);
        end
        checks++;
        if (bus.Inst_count !== 16'd6) begin
            errors++;
            $display("FAIL halt_cnt got %0d exp 6", bus.Inst_count);
        end
    endtask

    task automatic test_end_of_memory();
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        checks++;
        if (bus.Imem_addr !== 10'd0 || bus.Done !== 1'b0 ||
            bus.Inst_count !== 16'd0 || bus.Valid !== 1'b1) begin
            errors++;
            $display("FAIL restart1 got pc %0d d %0b c %0d exp 0/0/0",
                     bus.Imem_addr, bus.Done, bus.Inst_count);
        end
        repeat (1023) cycle();
        checks++;
        if (bus.Imem_addr !== 10'd1023 || bus.Valid !== 1'b1) begin
            errors++;
            $display("FAIL eom_last got pc %0d v %0b exp 1023/1",
                     bus.Imem_addr, bus.Valid);
        end
        cycle();
        checks++;
        if (bus.Imem_addr !== 10'd1023 || bus.Done !== 1'b1 ||
            bus.Inst_count !== 16'd1024) begin
            errors++;
            $display("FAIL eom_halt got pc %0d d %0b c %0d exp 1023/1/1024",
                     bus.Imem_addr, bus.Done, bus.Inst_count);
        end
        cycle();
        checks++;
        if (bus.Imem_addr !== 10'd1023 || bus.Done !== 1'b1) begin
            errors++;
            $display("FAIL eom_hold got pc %0d d %0b exp 1023/1",
                     bus.Imem_addr, bus.Done);
        end
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        checks++;
        if (bus.Imem_addr !== 10'd0 || bus.Done !== 1'b0 ||
            bus.Inst_count !== 16'd0) begin
            errors++;
            $display("FAIL restart2 got pc %0d d %0b c %0d exp 0/0/0",
                     bus.Imem_addr, bus.Done, bus.Inst_count);
        end
    endtask

    task automatic test_async_reset_lut();
        bus.Lut_we   = 1'b1;
        bus.Lut_idx  = 5'd3;
        bus.Lut_data = 10'd99;
        repeat (12) cycle();
        clear_inputs();
        checks++;
        if (bus.Imem_addr !== 10'd12) begin
            errors++;
            $display("FAIL ar_pc12 got %0d exp 12", bus.Imem_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.Valid !== 1'b0 || bus.Imem_addr !== 10'd0 ||
            bus.Mach_code !== 9'h000 || bus.Inst_count !== 16'd0) begin
            errors++;
            $display("FAIL ar_async got v %0b pc %0d m %h c %0d exp 0/0/000/0",
                     bus.Valid, bus.Imem_addr, bus.Mach_code,
                     bus.Inst_count);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        checks++;
        if (bus.Imem_addr !== 10'd0 || bus.Valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_idle got pc %0d v %0b exp 0/0",
                     bus.Imem_addr, bus.Valid);
        end
        bus.Start = 1'b1;
        cycle();
        bus.Start = 1'b0;
        bus.Jump  = 1'b1;
        bus.Jptr  = 5'd3;
        cycle();
        clear_inputs();
        checks++;
        if (bus.Imem_addr !== 10'd40) begin
            errors++;
            $display("FAIL ar_lut got %0d exp 40", bus.Imem_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            bus.Lut_we   = 1'b1;
            bus.Lut_idx  = 5'(i);
            bus.Lut_data = 10'($urandom_range(0, 1023));
            cycle();
        end
        clear_inputs();
        bus.Start = 1'b1;
        cycle();
        for (int n = 0; n < 3000; n++) begin
            bus.Start    = ($urandom_range(0, 99) < 30);
            bus.Stall    = ($urandom_range(0, 99) < 20);
            bus.Halt     = ($urandom_range(0, 99) < 3);
            bus.Jump     = ($urandom_range(0, 99) < 10);
            bus.Branch   = ($urandom_range(0, 99) < 20);
            bus.Jen      = 1'($urandom_range(0, 1));
            bus.Jptr     = 5'($urandom_range(0, 31));
            bus.Lut_we   = ($urandom_range(0, 99) < 10);
            bus.Lut_idx  = 5'($urandom_range(0, 31));
            bus.Lut_data = 10'($urandom_range(0, 1023));
            cycle();
            checks++;
            if (bus.Imem_addr !== 10'(m_pc)) begin
                errors++;
                $display("FAIL rnd_pc n %0d got %0d exp %0d",
                         n, bus.Imem_addr, m_pc);
            end
            checks++;
            if (bus.Valid !== (m_mode == M_RUN) ||
                bus.Done !== (m_mode == M_HALT)) begin
                errors++;
                $display("FAIL rnd_state n %0d got v %0b d %0b exp mode %0d",
                         n, bus.Valid, bus.Done, m_mode);
            end
            checks++;
            if (bus.Mach_code !== exp_mach()) begin
                errors++;
                $display("FAIL rnd_mach n %0d got %h exp %h",
                         n, bus.Mach_code, exp_mach());
            end
            checks++;
            if (bus.Inst_count !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_cnt n %0d got %0d exp %0d",
                         n, bus.Inst_count, m_cnt);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
        for (int i = 0; i < 32; i++) m_lut[i] = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_sequential();
        test_jump_branch();
        test_stall_priority();
        test_end_of_memory();
        test_async_reset_lut();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: PC_W, 10, program counter and instruction-memory address width.
REQ-002 Parameter: LUT_N, 32, number of jump-target entries, indexed by the 5-bit Jptr.
REQ-003 Clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  in IDLE: begin program at PC 0; in HALTED: restart at PC 0.
REQ-006 Stall  in  1  freeze PC, state and counter this cycle.
REQ-007 Halt  in  1  decoder flags the current instruction as a halt.
REQ-008 Jump  in  1  decoder flags an unconditional jump.
REQ-009 Branch  in  1  decoder flags a conditional branch (blt/beq).
REQ-010 Jen  in  1  branch condition result from the ALU.
REQ-011 Jptr  in  5  jump-target LUT index from the decoder.
REQ-012 Lut_we  in  1  write strobe for the jump-target LUT.
REQ-013 Lut_idx  in  5  LUT write index.
REQ-014 Lut_data  in  PC_W  LUT write data (absolute target address).
REQ-015 Imem_data  in  9  instruction word returned combinationally for Imem_addr.
REQ-016 Imem_addr  out  PC_W  current PC.
REQ-017 Mach_code  out  9  instruction word sent to the decoder.
REQ-018 Valid  out  1  Mach_code is a live instruction.
REQ-019 Done  out  1  program has halted.
REQ-020 Inst_count  out  16  count of retired (non-stalled RUN) cycles.

Function
REQ-021 The FSM SHALL have three states, IDLE, RUN and HALTED, with registered state.
REQ-022 In IDLE, Start=1 SHALL set PC to 0, clear Inst_count and enter RUN on the next edge.
REQ-023 In RUN, Valid SHALL be 1 and Mach_code SHALL equal Imem_data; in all other states Valid=0 and Mach_code=9'h000.
REQ-024 Imem_addr SHALL always equal the PC register.
REQ-025 In a RUN cycle with Stall=1, PC, state and Inst_count SHALL hold, and all other RUN inputs SHALL be ignored.
REQ-026 In a RUN cycle with Stall=0, the next PC SHALL be chosen by this priority (highest first):
- Halt=1: enter HALTED and hold PC.
- Jump=1, or Branch=1 with Jen=1: load PC from LUT[Jptr].
- Otherwise: PC+1.
REQ-027 Branch=1 with Jen=0 SHALL select PC+1.
REQ-028 In a non-halting RUN cycle with PC = 2^PC_W-1 and no taken jump, the block SHALL enter HALTED with PC held; PC SHALL NOT wrap to 0.
REQ-029 Every RUN cycle with Stall=0, including a halting cycle, SHALL increment Inst_count by 1; Inst_count SHALL saturate at 16'hFFFF.
REQ-030 Done SHALL be 1 exactly while in HALTED.
REQ-031 In HALTED, Start=1 SHALL set PC to 0, clear Inst_count, and enter RUN, so Done falls on that edge.
REQ-032 Lut_we=1 SHALL write Lut_data into LUT[Lut_idx] only in IDLE; writes in RUN or HALTED SHALL be ignored.
REQ-033 A LUT write and a Start in the same IDLE cycle SHALL both take effect.
REQ-034 The LUT read SHALL be combinational on Jptr; a target is used on the edge that ends the jump cycle (one-cycle redirect, no bubble).

Reset
REQ-035 Reset_n=0 SHALL asynchronously force: state IDLE, PC 0, Inst_count 0, Valid 0, Done 0, Mach_code 9'h000.
REQ-036 Reset SHALL NOT clear the LUT contents; LUT values are undefined until written.
REQ-037 Reset asserted mid-RUN SHALL abort the program immediately, with no further PC updates until Start.

Verification
REQ-038 Sequential fetch: LUT unwritten, Start, ROM words 0..4, no control inputs -> Imem_addr 0,1,2,3,4 on consecutive cycles; Mach_code tracks the ROM; Inst_count=5 after 5 cycles.
REQ-039 Jump and branch: LUT[3]=10'd40 written in IDLE; Jump=1 with Jptr=3 at PC 7 -> next PC 40; Branch=1, Jen=0 at PC 40 -> PC 41; Branch=1, Jen=1 with Jptr=3 -> PC 40.
REQ-040 Stall and priority: Stall=1 together with Halt=1 and Jump=1 at PC 5 -> PC stays 5, state RUN, count unchanged; next cycle with Stall=0, Halt=1, Jump=1 -> HALTED, Done=1, PC 5.
REQ-041 End of memory and restart: run to PC 1023 with no jump -> HALTED, PC 1023; Start -> PC 0, Done=0, Inst_count=0.
REQ-042 Async reset and LUT: Reset_n pulled low mid-cycle at PC 12 -> Valid=0 and PC=0 before the next edge; previously written LUT[3]=40 is still honoured after the next Start; Lut_we during RUN leaves LUT unchanged.
